// File: rtl/buffer_dispatch.sv
// buffer_dispatch
//   Write-side and drain-side manager for four DEPTH-slot packet buffers.
//   Incoming packets are appended to the tail of the buffer chosen by
//   pkt_dest. Head packets are offered one at a time on the shared out_*
//   port. A round-robin arbiter chooses among the non-empty buffers.
//   Each buffer is exposed in packed form: slot j occupies bits
//   [SW*j +: SW] as {data, valid}. Slot 0 is the oldest entry.
//
// Ports
//   clk, rst_n     rising-edge clock, synchronous active-low reset
//   flush          synchronous clear of all buffers and the rr pointer
//   pkt_valid/pkt_dest/pkt_data/pkt_ready   push side (pkt_ready comb)
//   out_valid/out_src/out_data/out_ready    pop side (out_* comb)
//   buffer1_o..buffer4_o                    registered packed buffer images
module buffer_dispatch #(
  parameter int unsigned DEPTH  = 6,
  parameter int unsigned DATA_W = 2
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            flush,
  input  logic                            pkt_valid,
  input  logic [1:0]                      pkt_dest,
  input  logic [DATA_W-1:0]               pkt_data,
  output logic                            pkt_ready,
  output logic                            out_valid,
  output logic [1:0]                      out_src,
  output logic [DATA_W-1:0]               out_data,
  input  logic                            out_ready,
  output logic [DEPTH*(DATA_W+1)-1:0]     buffer1_o,
  output logic [DEPTH*(DATA_W+1)-1:0]     buffer2_o,
  output logic [DEPTH*(DATA_W+1)-1:0]     buffer3_o,
  output logic [DEPTH*(DATA_W+1)-1:0]     buffer4_o
);

  localparam int unsigned SW = DATA_W + 1;
  localparam int unsigned BW = DEPTH * SW;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [BW-1:0] slots_q [4];
  logic [BW-1:0] slots_d [4];
  logic [CW-1:0] cnt_q   [4];
  logic [CW-1:0] cnt_d   [4];
  logic [1:0]    rr_q, rr_d;

  logic [1:0]    grant;
  logic [1:0]    scan;
  logic          found;
  logic          push;
  logic          pop;

  // Round-robin search starting at rr_q; the first buffer whose head slot
  // is valid wins.
  always_comb begin
    grant = '0;
    found = 1'b0;
    scan  = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      scan = rr_q + 2'(k);
      if (!found && slots_q[scan][0]) begin
        grant = scan;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    out_valid = found;
    out_src   = found ? grant : '0;
    out_data  = found ? slots_q[grant][SW-1:1] : '0;
    pkt_ready = (cnt_q[pkt_dest] < CW'(DEPTH)) && !flush;
    push      = pkt_valid && pkt_ready;
    pop       = out_valid && out_ready && !flush;
  end

  // Pop shift is applied before the push so a same-buffer push lands at
  // the post-shift tail index.
  always_comb begin
    rr_d = rr_q;
    if (pop) rr_d = grant + 2'd1;
    for (int unsigned b = 0; b < 4; b++) begin
      slots_d[b] = slots_q[b];
      cnt_d[b]   = cnt_q[b];
      if (pop && grant == 2'(b)) begin
        slots_d[b] = slots_q[b] >> SW;
        cnt_d[b]   = cnt_q[b] - CW'(1);
      end
      if (push && pkt_dest == 2'(b)) begin
        for (int unsigned j = 0; j < DEPTH; j++) begin
          if (cnt_d[b] == CW'(j)) slots_d[b][j*SW +: SW] = {pkt_data, 1'b1};
        end
        cnt_d[b] = cnt_d[b] + CW'(1);
      end
    end
    if (flush) begin
      rr_d = '0;
      for (int unsigned b = 0; b < 4; b++) begin
        slots_d[b] = '0;
        cnt_d[b]   = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_q <= '0;
      for (int unsigned b = 0; b < 4; b++) begin
        slots_q[b] <= '0;
        cnt_q[b]   <= '0;
      end
    end else begin
      rr_q <= rr_d;
      for (int unsigned b = 0; b < 4; b++) begin
        slots_q[b] <= slots_d[b];
        cnt_q[b]   <= cnt_d[b];
      end
    end
  end

  always_comb begin
    buffer1_o = slots_q[0];
    buffer2_o = slots_q[1];
    buffer3_o = slots_q[2];
    buffer4_o = slots_q[3];
  end

endmodule

// File: tb/tb_buffer_dispatch.sv
// tb_buffer_dispatch
//   Drives buffer_dispatch with directed scenarios followed by random
//   traffic. A queue-per-buffer reference model predicts the combinational
//   outputs and the packed buffer images every cycle.
module tb_buffer_dispatch;

  logic        clk = 1'b0;
  logic        rst_n, flush, pkt_valid, out_ready;
  logic [1:0]  pkt_dest, pkt_data;
  logic        pkt_ready, out_valid;
  logic [1:0]  out_src, out_data;
  logic [17:0] b1, b2, b3, b4;

  int n_chk = 0;
  int n_err = 0;

  int q [4][$];
  int rr = 0;
  bit model_ok = 0;

  buffer_dispatch #(.DEPTH(6), .DATA_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .pkt_valid(pkt_valid), .pkt_dest(pkt_dest), .pkt_data(pkt_data),
    .pkt_ready(pkt_ready),
    .out_valid(out_valid), .out_src(out_src), .out_data(out_data),
    .out_ready(out_ready),
    .buffer1_o(b1), .buffer2_o(b2), .buffer3_o(b3), .buffer4_o(b4)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [17:0] dut_buf(input int b);
    case (b)
      0: return b1;
      1: return b2;
      2: return b3;
      default: return b4;
    endcase
  endfunction

  function automatic logic [17:0] model_image(input int b);
    logic [17:0] r;
    logic [31:0] v;
    r = '0;
    for (int j = 0; j < q[b].size(); j++) begin
      v = q[b][j];
      r[3*j]     = 1'b1;
      r[3*j+1]   = v[0];
      r[3*j+2]   = v[1];
    end
    return r;
  endfunction

  // One clock cycle: apply inputs, check the predicted outputs, advance the model.
  task automatic step(input logic r, input logic f, input logic v,
                      input logic [1:0] d, input logic [1:0] dat, input logic ordy);
    int  g;
    bit  any;
    bit  rdy, pop, push;
    @(negedge clk);
    rst_n = r; flush = f; pkt_valid = v; pkt_dest = d; pkt_data = dat; out_ready = ordy;
    #1;
    any = 0; g = 0;
    for (int k = 0; k < 4; k++) begin
      if (!any && q[(rr + k) % 4].size() > 0) begin
        g = (rr + k) % 4;
        any = 1;
      end
    end
    rdy  = (q[d].size() < 6) && !f;
    pop  = any && ordy && !f;
    push = v && rdy;
    if (model_ok) begin
      check("pkt_ready", 32'(pkt_ready), 32'(rdy));
      check("out_valid", 32'(out_valid), 32'(any));
      check("out_src",   32'(out_src),   any ? 32'(g) : 32'd0);
      check("out_data",  32'(out_data),  any ? 32'(q[g][0]) : 32'd0);
      for (int b = 0; b < 4; b++)
        check($sformatf("buffer%0d_o", b + 1), 32'(dut_buf(b)), 32'(model_image(b)));
    end
    @(posedge clk);
    if (!r) begin
      for (int b = 0; b < 4; b++) q[b].delete();
      rr = 0;
      model_ok = 1;
    end else if (f) begin
      for (int b = 0; b < 4; b++) q[b].delete();
      rr = 0;
    end else begin
      if (pop) begin
        void'(q[g].pop_front());
        rr = (g + 1) % 4;
      end
      if (push) q[d].push_back(int'(dat));
    end
  endtask

  task automatic idle(input logic ordy);
    step(1, 0, 0, 2'd0, 2'd0, ordy);
  endtask

  initial begin
    rst_n = 0; flush = 0; pkt_valid = 0; pkt_dest = 0; pkt_data = 0; out_ready = 0;

    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    idle(0);
    #1;
    check("rst_pkt_ready", 32'(pkt_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);

    // Append 1,2,3 to buffer1 while downstream stalls.
    step(1, 0, 1, 0, 1, 0);
    step(1, 0, 1, 0, 2, 0);
    step(1, 0, 1, 0, 3, 0);
    idle(0);
    #1;
    check("lit_buffer1", 32'(b1), 32'(18'b000_000_000_111_101_011));
    check("lit_out_data", 32'(out_data), 32'd1);

    // Fill buffer3, reject a 7th push, pop with push still presented.
    step(1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) step(1, 0, 1, 2, 2'(i), 0);
    step(1, 0, 1, 2, 3, 0);
    step(1, 0, 1, 2, 3, 1);
    step(1, 0, 1, 2, 3, 0);
    idle(0);
    #1;
    check("lit_buffer3_slot5", 32'(b3[17:15]), 32'(3'b111));

    // One packet per buffer, drained in round-robin order.
    step(1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(1, 0, 1, 2'(i), 2'(i), 0);
    for (int i = 0; i < 5; i++) idle(1);

    // Fairness between buffers 0 and 1.
    step(1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 1, 0, 2'(i), 0);
      step(1, 0, 1, 1, 2'(i), 0);
    end
    for (int i = 0; i < 7; i++) idle(1);

    // Same-buffer push and pop in one cycle.
    step(1, 1, 0, 0, 0, 0);
    step(1, 0, 1, 1, 2, 0);
    step(1, 0, 1, 1, 3, 0);
    step(1, 0, 1, 1, 1, 1);
    idle(0);
    #1;
    check("lit_buffer2", 32'(b2), 32'(18'b000_000_000_000_011_111));
    check("lit_same_out_data", 32'(out_data), 32'd3);

    // Partial fill, flush with a push, then reset mid-stream.
    for (int i = 0; i < 8; i++) step(1, 0, 1, 2'(i % 4), 2'(i), 0);
    step(1, 1, 1, 0, 3, 1);
    idle(0);
    for (int i = 0; i < 8; i++) step(1, 0, 1, 2'(i % 4), 2'(i), i % 3 == 0);
    step(0, 0, 1, 1, 2, 1);
    idle(0);

    // Random traffic with occasional flush and reset.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 99) != 0,
           $urandom_range(0, 39) == 0,
           $urandom_range(0, 3) != 0,
           2'($urandom_range(0, 3)),
           2'($urandom_range(0, 3)),
           $urandom_range(0, 2) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule
